uart_command_decoder: RTL and testbench
=======================================

Name: uart_command_decoder

Overview:
Consumes the byte stream from the UART receiver and assembles 2-byte command frames: a sensor address byte followed by a command byte. It validates each byte, enforces an inter-byte timeout, and presents one complete command to the downstream sensor controller over a valid/ready handshake. It sits directly downstream of the UART receiver, in the divided-clock domain.

Parameters:
TIMEOUT_CYCLES, 50000, clock cycles allowed between the address byte and the command byte before the frame is abandoned (must be >= 2).
MAX_ADDR, 31, highest legal sensor address (must be <= 255).
MAX_CMD, 7, highest legal command code (must be <= 255).

Ports:
clock  input  1  Block clock (divided clock, same as the UART receiver).
reset  input  1  Synchronous, active-high reset.
has_data  input  1  One-cycle pulse from the UART receiver: data_received is valid this cycle.
data_received  input  8  Byte from the UART receiver.
cmd_ready  input  1  Downstream can accept the pending command.
cmd_valid  output  1  A complete, validated command is pending.
sensor_addr  output  8  Address of the pending command. Stable while cmd_valid is high.
command  output  8  Command code of the pending command. Stable while cmd_valid is high.
frame_error  output  1  One-cycle pulse: the frame was rejected.
error_code  output  2  Cause of the last rejection: 01 bad address, 10 bad command, 11 timeout. Holds until the next error.
overrun  output  1  One-cycle pulse: a byte arrived while a command was pending and was dropped.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high): state=IDLE, timer=0, cmd_valid=0, sensor_addr=0, command=0, frame_error=0, error_code=00, overrun=0.
- Reset asserted mid-frame or while a command is pending discards the partial frame or pending command. No error pulse is generated.
- States: IDLE, WAIT_CMD, PENDING.
- IDLE:
  - has_data with data_received <= MAX_ADDR: latch sensor_addr, clear the timer, go to WAIT_CMD.
  - has_data with data_received > MAX_ADDR: frame_error=1 for the next cycle, error_code=01, stay in IDLE.
- WAIT_CMD:
  - The timer increments every cycle without has_data.
  - has_data with data_received <= MAX_CMD: latch command, go to PENDING. cmd_valid goes high on the cycle after the has_data pulse (1-cycle latency).
  - has_data with data_received > MAX_CMD: frame_error pulse, error_code=10, go to IDLE.
  - Timer reaches TIMEOUT_CYCLES-1 with no has_data: frame_error pulse, error_code=11, go to IDLE.
  - has_data in the same cycle as timeout expiry: the byte wins. It is processed as the command byte and no timeout is reported.
- PENDING:
  - cmd_valid=1. sensor_addr and command are held constant.
  - Handshake completes in any cycle where cmd_valid and cmd_ready are both high. cmd_valid drops on the next cycle and the state returns to IDLE.
  - cmd_ready high before cmd_valid is ignored. cmd_valid never deasserts without a handshake, except on reset.
  - has_data while in PENDING, including the handshake cycle: the byte is dropped, overrun pulses for one cycle, and no state change results from the byte.
- Back-to-back frames: the earliest a new address byte can be accepted is the cycle after the handshake cycle.
- Single-byte pulses only: has_data is never high on consecutive cycles. If it is, each high cycle is treated as a separate byte.
- frame_error and overrun are never high on more than one consecutive cycle per event.
- sensor_addr and command keep their last values after the handshake; they are not cleared.

Test Plan:
1. Reset, then has_data with 0x05, then 3 cycles later has_data with 0x02, cmd_ready=1 -> cmd_valid high 1 cycle after the second pulse with sensor_addr=0x05 and command=0x02; cmd_valid low on the next cycle; state IDLE.
2. cmd_ready=0, send frame 0x1F/0x07, hold 10 cycles, then raise cmd_ready -> cmd_valid stays high with a stable 0x1F/0x07 for all 10 cycles and drops 1 cycle after cmd_ready rises; a byte 0x01 injected during the wait -> overrun pulse and the outputs are unchanged.
3. Address 0x20 -> frame_error pulse, error_code=01, no cmd_valid; then a legal frame 0x03/0x01 -> accepted normally.
4. Address 0x04, command 0x08 -> frame_error pulse, error_code=10, returns to IDLE; the next byte 0x04 is treated as an address.
5. TIMEOUT_CYCLES=16: address 0x02, then no byte -> frame_error with error_code=11 at the expiry cycle; repeat with the command byte arriving exactly on the expiry cycle -> command accepted, no error.
6. Assert reset in WAIT_CMD and again in PENDING -> all outputs return to their reset values, and the following legal frame decodes correctly.

Source files
------------

// File: rtl/uart_command_decoder.sv
// UART command frame decoder: assembles address/command byte pairs from the UART
// receiver, validates them, enforces an inter-byte timeout and hands complete
// commands to the sensor controller over a valid/ready handshake.
module uart_command_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_ADDR       = 31,
  parameter int unsigned MAX_CMD        = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       has_data,
  input  logic [7:0] data_received,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] sensor_addr,
  output logic [7:0] command,
  output logic       frame_error,
  output logic [1:0] error_code,
  output logic       overrun
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);

  localparam logic [7:0] MaxAddr = 8'(MAX_ADDR);
  localparam logic [7:0] MaxCmd  = 8'(MAX_CMD);

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrAddr    = 2'b01;
  localparam logic [1:0] ErrCmd     = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWaitCmd,
    StPending
  } state_e;

  state_e            state_q;
  logic [TimerW-1:0] timer_q;

  // Frame FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      cmd_valid   <= 1'b0;
      sensor_addr <= 8'h00;
      command     <= 8'h00;
      frame_error <= 1'b0;
      error_code  <= ErrNone;
      overrun     <= 1'b0;
    end else begin
      // Pulses last exactly one cycle per event.
      frame_error <= 1'b0;
      overrun     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (has_data) begin
            if (data_received <= MaxAddr) begin
              sensor_addr <= data_received;
              timer_q     <= '0;
              state_q     <= StWaitCmd;
            end else begin
              frame_error <= 1'b1;
              error_code  <= ErrAddr;
            end
          end
        end

        StWaitCmd: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (has_data) begin
            if (data_received <= MaxCmd) begin
              command   <= data_received;
              cmd_valid <= 1'b1;
              state_q   <= StPending;
            end else begin
              frame_error <= 1'b1;
              error_code  <= ErrCmd;
              state_q     <= StIdle;
            end
          end else if (timer_q == TimerLast) begin
            frame_error <= 1'b1;
            error_code  <= ErrTimeout;
            state_q     <= StIdle;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        StPending: begin
          // Bytes are dropped while a command is pending, handshake cycle included.
          if (has_data) begin
            overrun <= 1'b1;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: begin
          cmd_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_command_decoder.sv
// Self-checking bench for uart_command_decoder with a scoreboard of expected
// commands, error codes and overrun events.
module tb_uart_command_decoder;

  localparam int unsigned Timeout = 16;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] cmd;
  } frame_t;

  logic       clock;
  logic       reset;
  logic       has_data;
  logic [7:0] data_received;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] sensor_addr;
  logic [7:0] command;
  logic       frame_error;
  logic [1:0] error_code;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  frame_t     exp_cmd[$];
  logic [1:0] exp_err[$];
  int         exp_overrun = 0;

  uart_command_decoder #(
    .TIMEOUT_CYCLES(Timeout),
    .MAX_ADDR      (31),
    .MAX_CMD       (7)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .has_data     (has_data),
    .data_received(data_received),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .sensor_addr  (sensor_addr),
    .command      (command),
    .frame_error  (frame_error),
    .error_code   (error_code),
    .overrun      (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: pops the scoreboard on DUT events and checks pending-command stability.
  logic       pv, ph, pr, pfe, pov;
  logic [7:0] pa, pc;
  initial begin
    pv = 1'b0; ph = 1'b0; pr = 1'b1; pfe = 1'b0; pov = 1'b0; pa = 8'h00; pc = 8'h00;
  end

  always @(negedge clock) begin
    frame_t     got;
    frame_t     want;
    logic [1:0] werr;
    if (pv === 1'b1 && ph !== 1'b1 && pr !== 1'b1) begin
      checks++;
      if (cmd_valid !== 1'b1 || sensor_addr !== pa || command !== pc) begin
        errors++;
        $display("FAIL stable_pending: got valid=%b %h/%h required valid=1 %h/%h",
                 cmd_valid, sensor_addr, command, pa, pc);
      end
    end
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      checks++;
      got = {sensor_addr, command};
      if (exp_cmd.size() == 0) begin
        errors++;
        $display("FAIL handshake_unexpected: got %h/%h required no command", sensor_addr,
                 command);
      end else begin
        want = exp_cmd.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL handshake_frame: got %h/%h required %h/%h", got.addr, got.cmd,
                   want.addr, want.cmd);
        end
      end
    end
    if (frame_error === 1'b1) begin
      checks++;
      if (exp_err.size() == 0) begin
        errors++;
        $display("FAIL frame_error_unexpected: got code %b required no error", error_code);
      end else begin
        werr = exp_err.pop_front();
        if (error_code !== werr) begin
          errors++;
          $display("FAIL error_code: got %b required %b", error_code, werr);
        end
      end
      if (pfe === 1'b1) begin
        errors++;
        $display("FAIL frame_error_width: got 2-cycle pulse required 1-cycle pulse");
      end
    end
    if (overrun === 1'b1) begin
      checks++;
      if (exp_overrun == 0) begin
        errors++;
        $display("FAIL overrun_unexpected: got overrun=1 required 0");
      end else begin
        exp_overrun--;
      end
      if (pov === 1'b1) begin
        errors++;
        $display("FAIL overrun_width: got 2-cycle pulse required 1-cycle pulse");
      end
    end
    pv  = cmd_valid;
    ph  = cmd_valid & cmd_ready;
    pr  = reset;
    pfe = frame_error;
    pov = overrun;
    pa  = sensor_addr;
    pc  = command;
  end

  // Drive a byte for one clock edge; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    has_data      = 1'b1;
    data_received = b;
    @(posedge clock);
    #1;
    has_data      = 1'b0;
    data_received = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] c);
    frame_t f;
    f.addr = a;
    f.cmd  = c;
    exp_cmd.push_back(f);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || sensor_addr !== 8'h00 || command !== 8'h00) begin
      errors++;
      $display("FAIL reset_cmd: got %b %h/%h required 0 00/00", cmd_valid, sensor_addr,
               command);
    end
    checks++;
    if (frame_error !== 1'b0 || error_code !== 2'b00 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got fe=%b code=%b ov=%b required 0 00 0", frame_error,
               error_code, overrun);
    end
  endtask

  task automatic test_basic;
    cmd_ready = 1'b1;
    push_frame(8'h05, 8'h02);
    send_byte(8'h05);
    idle(2);
    send_byte(8'h02);
    checks++;
    if (cmd_valid !== 1'b1 || sensor_addr !== 8'h05 || command !== 8'h02) begin
      errors++;
      $display("FAIL basic_valid: got %b %h/%h required 1 05/02", cmd_valid, sensor_addr,
               command);
    end
    idle(1);
    checks++;
    if (cmd_valid !== 1'b0 || sensor_addr !== 8'h05 || command !== 8'h02) begin
      errors++;
      $display("FAIL basic_drop: got %b %h/%h required 0 05/02", cmd_valid, sensor_addr,
               command);
    end
  endtask

  task automatic test_hold_overrun;
    cmd_ready = 1'b0;
    push_frame(8'h1F, 8'h07);
    send_byte(8'h1F);
    idle(1);
    send_byte(8'h07);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        exp_overrun++;
        send_byte(8'h01);
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL hold_overrun: got %b required 1", overrun);
        end
      end else begin
        idle(1);
      end
      checks++;
      if (cmd_valid !== 1'b1 || sensor_addr !== 8'h1F || command !== 8'h07) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %b %h/%h required 1 1f/07", i, cmd_valid,
                 sensor_addr, command);
      end
    end
    cmd_ready = 1'b1;
    idle(1);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got %b required 0", cmd_valid);
    end
  endtask

  task automatic test_bad_addr;
    exp_err.push_back(2'b01);
    send_byte(8'h20);
    checks++;
    if (frame_error !== 1'b1 || error_code !== 2'b01 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr: got fe=%b code=%b valid=%b required 1 01 0", frame_error,
               error_code, cmd_valid);
    end
    idle(1);
    push_frame(8'h03, 8'h01);
    send_byte(8'h03);
    idle(1);
    send_byte(8'h01);
    checks++;
    if (cmd_valid !== 1'b1 || sensor_addr !== 8'h03 || command !== 8'h01 ||
        error_code !== 2'b01) begin
      errors++;
      $display("FAIL bad_addr_recover: got %b %h/%h code=%b required 1 03/01 01", cmd_valid,
               sensor_addr, command, error_code);
    end
    idle(1);
  endtask

  task automatic test_bad_cmd;
    exp_err.push_back(2'b10);
    send_byte(8'h04);
    idle(1);
    send_byte(8'h08);
    checks++;
    if (frame_error !== 1'b1 || error_code !== 2'b10 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd: got fe=%b code=%b valid=%b required 1 10 0", frame_error,
               error_code, cmd_valid);
    end
    push_frame(8'h04, 8'h05);
    idle(1);
    send_byte(8'h04);
    idle(1);
    send_byte(8'h05);
    checks++;
    if (cmd_valid !== 1'b1 || sensor_addr !== 8'h04 || command !== 8'h05) begin
      errors++;
      $display("FAIL bad_cmd_recover: got %b %h/%h required 1 04/05", cmd_valid,
               sensor_addr, command);
    end
    idle(1);
  endtask

  task automatic test_timeout;
    exp_err.push_back(2'b11);
    send_byte(8'h02);
    idle(Timeout - 1);
    checks++;
    if (frame_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b required 0", frame_error);
    end
    idle(1);
    checks++;
    if (frame_error !== 1'b1 || error_code !== 2'b11) begin
      errors++;
      $display("FAIL timeout_fire: got fe=%b code=%b required 1 11", frame_error,
               error_code);
    end
    idle(1);
    push_frame(8'h02, 8'h03);
    send_byte(8'h02);
    idle(Timeout - 1);
    send_byte(8'h03);
    checks++;
    if (cmd_valid !== 1'b1 || frame_error !== 1'b0 || command !== 8'h03) begin
      errors++;
      $display("FAIL timeout_edge: got valid=%b fe=%b cmd=%h required 1 0 03", cmd_valid,
               frame_error, command);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    cmd_ready = 1'b1;
    push_frame(8'h0A, 8'h03);
    send_byte(8'h0A);
    idle(1);
    send_byte(8'h03);
    // Byte on the handshake cycle is dropped as an overrun.
    exp_overrun++;
    send_byte(8'h11);
    checks++;
    if (overrun !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun: got ov=%b valid=%b required 1 0", overrun, cmd_valid);
    end
    push_frame(8'h0B, 8'h02);
    send_byte(8'h0B);
    idle(1);
    send_byte(8'h02);
    checks++;
    if (cmd_valid !== 1'b1 || sensor_addr !== 8'h0B || command !== 8'h02) begin
      errors++;
      $display("FAIL b2b_next: got %b %h/%h required 1 0b/02", cmd_valid, sensor_addr,
               command);
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    send_byte(8'h06);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || sensor_addr !== 8'h00 || error_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_wait: got %b addr=%h code=%b required 0 00 00", cmd_valid,
               sensor_addr, error_code);
    end
    idle(Timeout + 4);
    cmd_ready = 1'b0;
    send_byte(8'h07);
    idle(1);
    send_byte(8'h01);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || sensor_addr !== 8'h00 || command !== 8'h00 ||
        frame_error !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending: got %b %h/%h fe=%b ov=%b required 0 00/00 0 0",
               cmd_valid, sensor_addr, command, frame_error, overrun);
    end
    cmd_ready = 1'b1;
    push_frame(8'h09, 8'h04);
    send_byte(8'h09);
    idle(1);
    send_byte(8'h04);
    checks++;
    if (cmd_valid !== 1'b1 || sensor_addr !== 8'h09 || command !== 8'h04) begin
      errors++;
      $display("FAIL reset_recover: got %b %h/%h required 1 09/04", cmd_valid, sensor_addr,
               command);
    end
    idle(1);
  endtask

  task automatic test_drain;
    idle(4);
    checks++;
    if (exp_cmd.size() != 0 || exp_err.size() != 0 || exp_overrun != 0) begin
      errors++;
      $display("FAIL drain: got cmds=%0d errs=%0d ovs=%0d outstanding required 0 0 0",
               exp_cmd.size(), exp_err.size(), exp_overrun);
    end
  endtask

  initial begin
    reset         = 1'b1;
    has_data      = 1'b0;
    data_received = 8'h00;
    cmd_ready     = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_basic();
    test_hold_overrun();
    test_bad_addr();
    test_bad_cmd();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
